// File: rtl/cp0_multi_pkg.sv
// cp0_multi shared definitions: register numbers, exception codes,
// SR/Cause bit positions and small helpers used by the CP0 top.
package cp0_multi_pkg;

   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_SR       = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;
   localparam logic [4:0] ADDR_PRID     = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int SR_IE         = 0;
   localparam int SR_EXL        = 1;
   localparam int SR_IM_LSB     = 8;
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_IP_LSB  = 8;
   localparam int CAUSE_EXC_LSB = 2;

   // Return address: a faulting delay-slot instruction resumes at its branch.
   function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] vpc);
      return bd ? (vpc - 32'd4) : vpc;
   endfunction

   // Only address errors carry a meaningful faulting address.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == 5'(EXC_ADEL)) || (code == 5'(EXC_ADES));
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: prescaler, free-running Count, Compare and sticky timer_irq.
// The prescaler is a down-counter; Count advances on its terminal count.
module cp0_timer
   import cp0_multi_pkg::*;
#(
   parameter int TIMER_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wd,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_irq
);

   localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TIMER_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [31:0]      count_inc;
   logic             hit;

   assign tick      = (div_cnt == '0);
   assign count_inc = count + 32'd1;
   // A Count write suppresses the increment, so it cannot produce a match.
   assign hit       = tick & ~count_we & (compare != 32'd0) & (count_inc == compare);

   // Prescaler: reloading on a Count write realigns the phase to a fresh period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 div_cnt <= DIV_RELOAD;
      else if (count_we || tick)  div_cnt <= DIV_RELOAD;
      else                        div_cnt <= div_cnt - 1'b1;
   end

   // Count: write wins over increment; wraps naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         count <= '0;
      else if (count_we)  count <= wd;
      else if (tick)      count <= count_inc;
   end

   // Compare register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           compare <= '0;
      else if (compare_we)  compare <= wd;
   end

   // Sticky pending flag; a Compare write clears it unless the new value also matches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           timer_irq <= 1'b0;
      else if (compare_we)  timer_irq <= hit & (wd == count_inc);
      else if (hit)         timer_irq <= 1'b1;
   end

endmodule

// File: rtl/cp0_multi.sv
// cp0_multi: M-stage coprocessor 0 with parametrised interrupt lines,
// BadVAddr, PRId and an optional Count/Compare timer (CP0_TIMER_EN).
module cp0_multi
   import cp0_multi_pkg::*;
#(
   parameter int          NUM_HWINT = 6,
   parameter logic [31:0] PRID      = 32'h0000_2530,
   parameter int          TIMER_DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 WE,
   input  logic [4:0]           Address,
   input  logic [31:0]          WD,
   input  logic                 BD_in,
   input  logic [31:0]          VPC,
   input  logic [31:0]          VAddr_in,
   input  logic [4:0]           ExcCode_in,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 EXLClr,
   output logic                 req,
   output logic [31:0]          EPC,
   output logic [31:0]          D_out,
   output logic                 timer_irq
);

   if (NUM_HWINT < 1 || NUM_HWINT > 8) begin : g_bad_hwint
      $error("cp0_multi: NUM_HWINT out of range");
   end
   if (TIMER_DIV < 1 || TIMER_DIV > 256) begin : g_bad_div
      $error("cp0_multi: TIMER_DIV out of range");
   end

   logic                 ie, exl, bd;
   logic [NUM_HWINT-1:0] im, ip, ip_eff;
   logic [4:0]           exc_code;
   logic [31:0]          epc_r, badvaddr;
   logic [31:0]          count_val, compare_val;
   logic [31:0]          sr_rd, cause_rd;
   logic                 ext_int, int_exc, wr_en;

`ifdef CP0_TIMER_EN
   logic count_we, compare_we;
   assign count_we   = wr_en & (Address == ADDR_COUNT);
   assign compare_we = wr_en & (Address == ADDR_COMPARE);

   cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (count_we),
      .compare_we (compare_we),
      .wd         (WD),
      .count      (count_val),
      .compare    (compare_val),
      .timer_irq  (timer_irq)
   );
`else
   assign count_val   = '0;
   assign compare_val = '0;
   assign timer_irq   = 1'b0;
`endif

   // Timer shares the top interrupt line with the external source.
   always_comb begin
      ip_eff                = HWInt;
      ip_eff[NUM_HWINT-1]   = HWInt[NUM_HWINT-1] | timer_irq;
   end

   assign ext_int = (|(ip_eff & im)) & ie & ~exl;
   assign int_exc = (ExcCode_in != 5'd0) & ~exl;
   assign req     = ext_int | int_exc;
   assign wr_en   = WE & ~EXLClr & ~req;
   assign EPC     = epc_r;

   // Architectural state; eret beats exception entry, which beats mtc0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ie       <= 1'b0;
         exl      <= 1'b0;
         im       <= '0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc_r    <= '0;
         badvaddr <= '0;
      end else begin
         ip <= ip_eff;
         if (EXLClr) begin
            exl <= 1'b0;
         end else if (req) begin
            exl      <= 1'b1;
            bd       <= BD_in;
            epc_r    <= epc_of(BD_in, VPC);
            exc_code <= ext_int ? 5'(EXC_INT) : ExcCode_in;
            if (!ext_int && is_addr_exc(ExcCode_in)) badvaddr <= VAddr_in;
         end else if (WE) begin
            case (Address)
               ADDR_SR: begin
                  ie  <= WD[SR_IE];
                  exl <= WD[SR_EXL];
                  im  <= WD[SR_IM_LSB +: NUM_HWINT];
               end
               ADDR_EPC: epc_r <= WD;
               default: ;
            endcase
         end
      end
   end

   // Register images as seen by mfc0.
   always_comb begin
      sr_rd                            = '0;
      sr_rd[SR_IE]                     = ie;
      sr_rd[SR_EXL]                    = exl;
      sr_rd[SR_IM_LSB +: NUM_HWINT]    = im;
      cause_rd                         = '0;
      cause_rd[CAUSE_BD]               = bd;
      cause_rd[CAUSE_IP_LSB +: NUM_HWINT] = ip;
      cause_rd[CAUSE_EXC_LSB +: 5]     = exc_code;
   end

   // Read mux: pre-edge values, no bypass of a same-cycle write.
   always_comb begin
      D_out = '0;
      case (Address)
         ADDR_SR:       D_out = sr_rd;
         ADDR_CAUSE:    D_out = cause_rd;
         ADDR_EPC:      D_out = epc_r;
         ADDR_PRID:     D_out = PRID;
         ADDR_BADVADDR: D_out = badvaddr;
         ADDR_COUNT:    D_out = count_val;
         ADDR_COMPARE:  D_out = compare_val;
         default:       D_out = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_multi.sv
// Directed bench for cp0_multi; expected values queue up as stimulus is applied.
module tb_cp0_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        WE;
   logic [4:0]  Address;
   logic [31:0] WD;
   logic        BD_in;
   logic [31:0] VPC;
   logic [31:0] VAddr_in;
   logic [4:0]  ExcCode_in;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        req;
   logic [31:0] EPC;
   logic [31:0] D_out;
   logic        timer_irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   cp0_multi dut (
      .clk        (clk),
      .reset      (reset),
      .WE         (WE),
      .Address    (Address),
      .WD         (WD),
      .BD_in      (BD_in),
      .VPC        (VPC),
      .VAddr_in   (VAddr_in),
      .ExcCode_in (ExcCode_in),
      .HWInt      (HWInt),
      .EXLClr     (EXLClr),
      .req        (req),
      .EPC        (EPC),
      .D_out      (D_out),
      .timer_irq  (timer_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
      push(e);
      Address = a;
      #1;
      chk(tag, D_out);
   endtask

   task automatic chk_sig(input string tag, input logic [31:0] obs_now, input logic [31:0] e);
      push(e);
      chk(tag, obs_now);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WE = 1'b1; Address = a; WD = d;
      step();
      WE = 1'b0;
   endtask

   initial begin
      reset = 1'b0; WE = 1'b0; Address = '0; WD = '0; BD_in = 1'b0;
      VPC = '0; VAddr_in = '0; ExcCode_in = '0; HWInt = '0; EXLClr = 1'b0;
      #1;
      chk_sig("rst_req", {31'd0, req}, 32'd0);
      chk_sig("rst_epc", EPC, 32'd0);
      chk_sig("rst_tirq", {31'd0, timer_irq}, 32'd0);
      chk_rd("rst_sr", 5'd12, 32'd0);
      chk_rd("rst_cause", 5'd13, 32'd0);
      chk_rd("rst_prid", 5'd15, 32'h0000_2530);
      chk_rd("rst_badva", 5'd8, 32'd0);
      chk_rd("rst_count", 5'd9, 32'd0);
      chk_rd("unmapped", 5'd3, 32'd0);
      step(); step();
      reset = 1'b1;

      // External interrupt, IM[10] enabled.
      wr(5'd12, 32'h0000_0401);
      HWInt = 6'b000100; VPC = 32'h0000_3010;
      #1;
      chk_sig("t1_req", {31'd0, req}, 32'd1);
      step();
      chk_sig("t1_req_masked", {31'd0, req}, 32'd0);
      chk_rd("t1_cause", 5'd13, 32'h0000_0400);
      chk_rd("t1_sr", 5'd12, 32'h0000_0403);
      chk_sig("t1_epc", EPC, 32'h0000_3010);
      HWInt = '0;

      // Address error in a delay slot.
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      chk_rd("t2_sr_clr", 5'd12, 32'h0000_0401);
      ExcCode_in = 5'd4; BD_in = 1'b1; VPC = 32'h0000_3008; VAddr_in = 32'h0000_0003;
      #1;
      chk_sig("t2_req", {31'd0, req}, 32'd1);
      step();
      ExcCode_in = '0; BD_in = 1'b0;
      chk_sig("t2_epc", EPC, 32'h0000_3004);
      chk_rd("t2_cause", 5'd13, 32'h8000_0010);
      chk_rd("t2_badva", 5'd8, 32'h0000_0003);

      // Overflow must not touch BadVAddr.
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      ExcCode_in = 5'd12; VPC = 32'h0000_3020; VAddr_in = 32'hAAAA_0000;
      step();
      ExcCode_in = '0;
      chk_rd("ov_cause", 5'd13, 32'h0000_0030);
      chk_rd("ov_badva", 5'd8, 32'h0000_0003);
      chk_sig("ov_epc", EPC, 32'h0000_3020);

      // EXL masks internal exceptions; eret ignores a pending request.
      ExcCode_in = 5'd10;
      #1;
      chk_sig("t3_ri_masked", {31'd0, req}, 32'd0);
      ExcCode_in = '0;
      HWInt = 6'b000100; EXLClr = 1'b1;
      #1;
      chk_sig("t3_req_eret", {31'd0, req}, 32'd0);
      step();
      EXLClr = 1'b0;
      #1;
      chk_sig("t3_req_rise", {31'd0, req}, 32'd1);
      chk_rd("t3_sr", 5'd12, 32'h0000_0401);

      // mtc0 EPC collides with exception entry: exception wins.
      VPC = 32'h0000_4000; BD_in = 1'b0;
      WE = 1'b1; Address = 5'd14; WD = 32'hDEAD_BEEF;
      step();
      WE = 1'b0; HWInt = '0;
      chk_sig("t4_epc", EPC, 32'h0000_4000);
      chk_rd("t4_sr", 5'd12, 32'h0000_0403);
      wr(5'd15, 32'hFFFF_FFFF);
      chk_rd("t4_prid", 5'd15, 32'h0000_2530);
      wr(5'd8, 32'h1234_0000);
      chk_rd("t4_badva_ro", 5'd8, 32'h0000_0003);
      wr(5'd13, 32'hFFFF_FFFF);
      chk_rd("t4_cause_ro", 5'd13, 32'h0000_0000);
      wr(5'd14, 32'h1234_5678);
      chk_rd("t4_epc_wr", 5'd14, 32'h1234_5678);
      wr(5'd12, 32'hFFFF_FFFF);
      chk_rd("t4_sr_mask", 5'd12, 32'h0000_3F03);

`ifdef CP0_TIMER_EN
      wr(5'd11, 32'h0000_0001);
      wr(5'd9, 32'hFFFF_FFFE);
      chk_rd("t5_count_wr", 5'd9, 32'hFFFF_FFFE);
      step();
      chk_rd("t5_count_max", 5'd9, 32'hFFFF_FFFF);
      step();
      chk_rd("t5_count_wrap", 5'd9, 32'h0000_0000);
      chk_sig("t5_irq_early", {31'd0, timer_irq}, 32'd0);
      step();
      chk_sig("t5_irq", {31'd0, timer_irq}, 32'd1);
      step();
      chk_rd("t5_cause_ip", 5'd13, 32'h0000_2000);
      wr(5'd11, 32'h0000_0005);
      chk_sig("t5_irq_clr", {31'd0, timer_irq}, 32'd0);
`else
      wr(5'd9, 32'h0000_0055);
      chk_rd("t5_count_off", 5'd9, 32'd0);
      wr(5'd11, 32'h0000_0007);
      chk_rd("t5_compare_off", 5'd11, 32'd0);
      chk_sig("t5_irq_off", {31'd0, timer_irq}, 32'd0);
`endif

      // Asynchronous reset while an interrupt request is active.
      EXLClr = 1'b1; step(); EXLClr = 1'b0;
      HWInt = 6'b000100;
      #1;
      chk_sig("t6_req_pre", {31'd0, req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk_sig("t6_req", {31'd0, req}, 32'd0);
      chk_rd("t6_sr", 5'd12, 32'd0);
      chk_rd("t6_cause", 5'd13, 32'd0);
      chk_sig("t6_epc", EPC, 32'd0);
      step();
      reset = 1'b1;
      HWInt = '0;
      step();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected values left unchecked", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
